// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs an 8-bit AXI-Stream byte stream little-endian into
// 32-bit words with tstrb/tlast. Partial final words are zero-filled. Output
// packets are cut at MAX_WORDS words. Any remaining bytes start a new packet.
module axis_byte_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      axis_aclk,
  input  logic                      axis_reset,
  input  logic [7:0]                s00_axis_tdata,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  output logic [15:0]               pkt_count,
  output logic                      split_flag
);

  // state | meaning
  // ST_IDLE | no packet open, next byte starts a packet
  // ST_PKT  | packet open, bytes are being packed
  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WCNT_LAST = ADDR_WIDTH'(MAX_WORDS - 1);

  state_t                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [23:0]             acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [STRB_W-1:0]       tstrb_q, tstrb_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [15:0]             pkt_count_q, pkt_count_d;
  logic                    split_q, split_d;

  logic                    s_ready;
  logic                    accept;
  logic                    word_done;
  logic                    out_last;
  logic [31:0]             word_c;
  logic [3:0]              strb_c;

  // Input ready only depends on the output register being free or draining.
  assign s_ready   = !axis_reset && (!tvalid_q || m00_axis_tready);
  assign accept    = s00_axis_tvalid && s_ready;
  assign word_done = (lane_q == 2'd3) || s00_axis_tlast;
  assign out_last  = s00_axis_tlast || (wcnt_q == WCNT_LAST);

  // Next-state logic: byte packing, word emission, packet bookkeeping.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    tdata_d     = tdata_q;
    tstrb_d     = tstrb_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pkt_count_d = pkt_count_q;
    split_d     = split_q;
    word_c      = '0;
    strb_c      = '0;

    case (lane_q)
      2'd0:    begin word_c = {24'd0, s00_axis_tdata};              strb_c = 4'b0001; end
      2'd1:    begin word_c = {16'd0, s00_axis_tdata, acc_q[7:0]};  strb_c = 4'b0011; end
      2'd2:    begin word_c = {8'd0, s00_axis_tdata, acc_q[15:0]};  strb_c = 4'b0111; end
      default: begin word_c = {s00_axis_tdata, acc_q};              strb_c = 4'b1111; end
    endcase

    if (m00_axis_tready) tvalid_d = 1'b0;

    if (accept) begin
      state_d = ST_PKT;
      if (word_done) begin
        tdata_d  = DATA_WIDTH'(word_c);
        tstrb_d  = STRB_W'(strb_c);
        tvalid_d = 1'b1;
        tlast_d  = out_last;
        lane_d   = 2'd0;
        acc_d    = '0;
        if (out_last) begin
          wcnt_d      = '0;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = ST_IDLE;
          // Cut at the depth boundary rather than at the input packet end.
          if (!s00_axis_tlast) split_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + ADDR_WIDTH'(1);
        end
      end else begin
        case (lane_q)
          2'd0:    acc_d[7:0]   = s00_axis_tdata;
          2'd1:    acc_d[15:8]  = s00_axis_tdata;
          default: acc_d[23:16] = s00_axis_tdata;
        endcase
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // State register with synchronous reset; reset drops any partial/pending word.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      pkt_count_q <= '0;
      split_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      pkt_count_q <= pkt_count_d;
      split_q     <= split_d;
    end
  end

  assign s00_axis_tready = s_ready;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign pkt_count       = pkt_count_q;
  assign split_flag      = split_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer: a default instance (MAX_WORDS=4096) and a
// small-depth instance (MAX_WORDS=2) to exercise packet splitting.
module tb_axis_byte_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [7:0]  sd  [2];
  logic        sv  [2];
  logic        sl  [2];
  logic        sr  [2];
  logic [31:0] md  [2];
  logic [3:0]  ms  [2];
  logic        mv  [2];
  logic        ml  [2];
  logic        mr  [2];
  logic [15:0] pc  [2];
  logic        sf  [2];

  int          bp_mode [2];
  int          vectors = 0;
  int          miscompares = 0;

  word_t       exp0[$], exp1[$], got0[$], got1[$];
  logic [7:0]  pkt_b[$];
  logic [15:0] mpk [2];
  bit          msplit [2];

  always #5 clk = ~clk;

  axis_byte_packer u0 (
    .axis_aclk(clk), .axis_reset(rst[0]),
    .s00_axis_tdata(sd[0]), .s00_axis_tvalid(sv[0]), .s00_axis_tlast(sl[0]),
    .s00_axis_tready(sr[0]),
    .m00_axis_tdata(md[0]), .m00_axis_tstrb(ms[0]), .m00_axis_tvalid(mv[0]),
    .m00_axis_tlast(ml[0]), .m00_axis_tready(mr[0]),
    .pkt_count(pc[0]), .split_flag(sf[0])
  );

  axis_byte_packer #(.MAX_WORDS(2), .ADDR_WIDTH(2)) u1 (
    .axis_aclk(clk), .axis_reset(rst[1]),
    .s00_axis_tdata(sd[1]), .s00_axis_tvalid(sv[1]), .s00_axis_tlast(sl[1]),
    .s00_axis_tready(sr[1]),
    .m00_axis_tdata(md[1]), .m00_axis_tstrb(ms[1]), .m00_axis_tvalid(mv[1]),
    .m00_axis_tlast(ml[1]), .m00_axis_tready(mr[1]),
    .pkt_count(pc[1]), .split_flag(sf[1])
  );

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      mr[i] = (bp_mode[i] == 0) ? 1'b1 : (bp_mode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Output monitor: a word transfers at the next edge when valid && ready.
  always @(negedge clk) begin
    if (mv[0] && mr[0] && !rst[0]) got0.push_back('{md[0], ms[0], ml[0]});
    if (mv[1] && mr[1] && !rst[1]) got1.push_back('{md[1], ms[1], ml[1]});
  end

  function automatic int gsize(int sel);
    return (sel == 1) ? got1.size() : got0.size();
  endfunction

  // Packet-level reference: chop the byte list into 4-byte words and cut
  // output packets every MAX_WORDS words.
  task automatic model_packet(int sel);
    int n, nw, mw;
    n  = pkt_b.size();
    nw = (n + 3) / 4;
    mw = (sel == 1) ? 2 : 4096;
    for (int i = 0; i < nw; i++) begin
      word_t w;
      int    cnt;
      cnt = (n - 4 * i >= 4) ? 4 : n - 4 * i;
      w.d = '0;
      for (int k = 0; k < cnt; k++) w.d[8*k +: 8] = pkt_b[4*i + k];
      w.s = 4'((1 << cnt) - 1);
      w.l = (i == nw - 1) || (i % mw == mw - 1);
      if (sel == 1) exp1.push_back(w); else exp0.push_back(w);
      if (w.l) mpk[sel] = mpk[sel] + 16'd1;
      if (w.l && i != nw - 1) msplit[sel] = 1'b1;
    end
  endtask

  // Present one byte (called just after a rising edge) and hold it until accepted.
  task automatic drive_byte(int sel, logic [7:0] b, logic last, int gap);
    int cyc;
    for (int g = 0; g < gap; g++) begin
      sv[sel] = 1'b0;
      @(posedge clk); #1;
    end
    sd[sel] = b; sl[sel] = last; sv[sel] = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (sr[sel]) break;
      cyc++;
      if (cyc > 500) begin
        $display("FAIL accept_timeout: dut%0d byte %h not accepted, tready=%b required 1", sel, b, sr[sel]);
        miscompares++;
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_packet(int sel, int maxgap);
    for (int i = 0; i < pkt_b.size(); i++)
      drive_byte(sel, pkt_b[i], (i == pkt_b.size() - 1), $urandom_range(0, maxgap));
    sv[sel] = 1'b0; sl[sel] = 1'b0;
    model_packet(sel);
  endtask

  task automatic wait_words(int sel, int n);
    int cyc;
    cyc = 0;
    while (gsize(sel) < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    vectors++;
    if (gsize(sel) < n) begin
      $display("FAIL word_timeout: dut%0d got %0d words, required %0d", sel, gsize(sel), n);
      miscompares++;
    end
  endtask

  task automatic clear_q();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (sr[i] !== 1'b0 || mv[i] !== 1'b0 || ml[i] !== 1'b0 || md[i] !== 32'h0 ||
          ms[i] !== 4'h0 || pc[i] !== 16'h0 || sf[i] !== 1'b0) begin
        $display("FAIL reset_values: dut%0d tready=%b tvalid=%b tlast=%b tdata=%h tstrb=%h pkt=%h split=%b, required all 0",
                 i, sr[i], mv[i], ml[i], md[i], ms[i], pc[i], sf[i]);
        miscompares++;
      end
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    mpk[0] = '0; mpk[1] = '0; msplit[0] = 0; msplit[1] = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (sr[i] !== 1'b1 || mv[i] !== 1'b0) begin
        $display("FAIL reset_release: dut%0d tready=%b tvalid=%b, required 1/0", i, sr[i], mv[i]);
        miscompares++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    word_t req[4];
    req[0] = '{32'h04030201, 4'hF, 1'b0};
    req[1] = '{32'h08070605, 4'hF, 1'b1};
    req[2] = '{32'hDDCCBBAA, 4'hF, 1'b0};
    req[3] = '{32'h000000EE, 4'h1, 1'b1};
    pkt_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_packet(0, 0);
    wait_words(0, 2);
    @(negedge clk);
    vectors++;
    if (pc[0] !== 16'd1) begin
      $display("FAIL basic_pkt_count: got %0d required 1", pc[0]); miscompares++;
    end
    pkt_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_packet(0, 1);
    wait_words(0, 4);
    for (int i = 0; i < 4 && i < got0.size(); i++) begin
      vectors++;
      if (got0[i] !== req[i]) begin
        $display("FAIL basic_word%0d: got %h/%h/%b required %h/%h/%b",
                 i, got0[i].d, got0[i].s, got0[i].l, req[i].d, req[i].s, req[i].l);
        miscompares++;
      end
    end
    @(negedge clk);
    vectors++;
    if (pc[0] !== 16'd2) begin
      $display("FAIL basic_pkt_count2: got %0d required 2", pc[0]); miscompares++;
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_single_latency();
    sd[0] = 8'h55; sl[0] = 1'b1; sv[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (sr[0] !== 1'b1) begin
      $display("FAIL single_ready: got %b required 1", sr[0]); miscompares++;
    end
    @(posedge clk); #1;
    sv[0] = 1'b0; sl[0] = 1'b0;
    vectors++;
    if (mv[0] !== 1'b1 || md[0] !== 32'h00000055 || ms[0] !== 4'h1 || ml[0] !== 1'b1) begin
      $display("FAIL single_word: got v=%b %h/%h/%b required 1 00000055/1/1", mv[0], md[0], ms[0], ml[0]);
      miscompares++;
    end
    pkt_b = '{8'h55};
    model_packet(0);
    wait_words(0, 1);
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_backpressure();
    bp_mode[0] = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive_byte(0, 8'(8'h10 + i), 1'b0, 0);
    sd[0] = 8'h14; sl[0] = 1'b0; sv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (sr[0] !== 1'b0 || mv[0] !== 1'b1 || md[0] !== 32'h13121110 || ms[0] !== 4'hF || ml[0] !== 1'b0) begin
        $display("FAIL bp_hold%0d: tready=%b v=%b %h/%h/%b required 0 1 13121110/f/0",
                 c, sr[0], mv[0], md[0], ms[0], ml[0]);
        miscompares++;
      end
    end
    bp_mode[0] = 0;
    @(negedge clk);
    vectors++;
    if (sr[0] !== 1'b1) begin
      $display("FAIL bp_release_ready: got %b required 1", sr[0]); miscompares++;
    end
    @(posedge clk); #1;
    drive_byte(0, 8'h15, 1'b0, 0);
    drive_byte(0, 8'h16, 1'b0, 0);
    drive_byte(0, 8'h17, 1'b1, 0);
    sv[0] = 1'b0; sl[0] = 1'b0;
    pkt_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    model_packet(0);
    wait_words(0, exp0.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      vectors++;
      if (got0[i] !== exp0[i]) begin
        $display("FAIL bp_word%0d: got %h/%h/%b required %h/%h/%b",
                 i, got0[i].d, got0[i].s, got0[i].l, exp0[i].d, exp0[i].s, exp0[i].l);
        miscompares++;
      end
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_split();
    word_t req[3];
    req[0] = '{32'h03020100, 4'hF, 1'b0};
    req[1] = '{32'h07060504, 4'hF, 1'b1};
    req[2] = '{32'h0B0A0908, 4'hF, 1'b1};
    pkt_b.delete();
    for (int i = 0; i < 12; i++) pkt_b.push_back(8'(i));
    send_packet(1, 0);
    wait_words(1, 3);
    for (int i = 0; i < 3 && i < got1.size(); i++) begin
      vectors++;
      if (got1[i] !== req[i]) begin
        $display("FAIL split_word%0d: got %h/%h/%b required %h/%h/%b",
                 i, got1[i].d, got1[i].s, got1[i].l, req[i].d, req[i].s, req[i].l);
        miscompares++;
      end
    end
    @(negedge clk);
    vectors++;
    if (sf[1] !== 1'b1 || pc[1] !== 16'd2) begin
      $display("FAIL split_flags: split=%b pkt=%0d required 1/2", sf[1], pc[1]); miscompares++;
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_reset_mid();
    drive_byte(0, 8'hA1, 1'b0, 0);
    drive_byte(0, 8'hA2, 1'b0, 0);
    sv[0] = 1'b0;
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    mpk[0] = '0; msplit[0] = 0;
    pkt_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(0, 0);
    wait_words(0, 1);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (got0.size() != 1) begin
      $display("FAIL rstmid_count: got %0d words required 1", got0.size()); miscompares++;
    end
    if (got0.size() >= 1) begin
      vectors++;
      if (got0[0] !== word_t'{32'h44332211, 4'hF, 1'b1}) begin
        $display("FAIL rstmid_word: got %h/%h/%b required 44332211/f/1", got0[0].d, got0[0].s, got0[0].l);
        miscompares++;
      end
    end
    vectors++;
    if (pc[0] !== 16'd1) begin
      $display("FAIL rstmid_pkt_count: got %0d required 1", pc[0]); miscompares++;
    end
    clear_q();
  endtask

  task automatic test_random(int sel);
    word_t g[$], e[$];
    bp_mode[sel] = 1;
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 20);
      pkt_b.delete();
      for (int i = 0; i < len; i++) pkt_b.push_back(8'($urandom));
      send_packet(sel, 2);
    end
    wait_words(sel, (sel == 1) ? exp1.size() : exp0.size());
    bp_mode[sel] = 0;
    repeat (4) @(posedge clk);
    #1;
    g = (sel == 1) ? got1 : got0;
    e = (sel == 1) ? exp1 : exp0;
    vectors++;
    if (g.size() != e.size()) begin
      $display("FAIL rand%0d_count: got %0d words required %0d", sel, g.size(), e.size()); miscompares++;
    end
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      vectors++;
      if (g[i] !== e[i]) begin
        $display("FAIL rand%0d_word%0d: got %h/%h/%b required %h/%h/%b",
                 sel, i, g[i].d, g[i].s, g[i].l, e[i].d, e[i].s, e[i].l);
        miscompares++;
      end
    end
    vectors++;
    if (pc[sel] !== mpk[sel] || sf[sel] !== msplit[sel]) begin
      $display("FAIL rand%0d_status: pkt=%0d split=%b required %0d/%b", sel, pc[sel], sf[sel], mpk[sel], msplit[sel]);
      miscompares++;
    end
    clear_q();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; sd[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0; mr[i] = 1'b1;
      bp_mode[i] = 0; mpk[i] = '0; msplit[i] = 0;
    end
    test_reset();
    test_basic();
    test_single_latency();
    test_backpressure();
    test_split();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
